// File: rtl/hpdcache_plru_sched.sv
// hpdcache_plru_sched: schedules hit updates (round-robin into an in-order FIFO) and refill victim selections onto a one-op-per-cycle PLRU
//  clk_i, rst_i                 clock, synchronous active-high reset
//  updt_*                       NREQ hit-update requesters (valid/ready, set, one-hot way)
//  repl_*                       victim selection request (valid/ready, set, directory bits, updt_plru)
//  repl_rsp_*                   victim way response (valid/ready, one-hot way)
//  plru_updt_*                  PLRU update strobe with set/way
//  plru_repl_*, plru_victim_*   PLRU replacement strobe, pass-through bits and returned victim
module hpdcache_plru_sched #(
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int NREQ       = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 4,
   localparam int SETW      = $clog2(SETS)
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      updt_valid_i,
   output logic [NREQ-1:0]      updt_ready_o,
   input  logic [NREQ*SETW-1:0] updt_set_i,
   input  logic [NREQ*WAYS-1:0] updt_way_i,
   input  logic                 repl_valid_i,
   output logic                 repl_ready_o,
   input  logic [SETW-1:0]      repl_set_i,
   input  logic [WAYS-1:0]      repl_dir_valid_i,
   input  logic [WAYS-1:0]      repl_dir_wb_i,
   input  logic [WAYS-1:0]      repl_dir_dirty_i,
   input  logic                 repl_updt_plru_i,
   output logic                 repl_rsp_valid_o,
   input  logic                 repl_rsp_ready_i,
   output logic [WAYS-1:0]      repl_rsp_way_o,
   output logic                 plru_updt_o,
   output logic [SETW-1:0]      plru_updt_set_o,
   output logic [WAYS-1:0]      plru_updt_way_o,
   output logic                 plru_repl_o,
   output logic [SETW-1:0]      plru_repl_set_o,
   output logic [WAYS-1:0]      plru_repl_dir_valid_o,
   output logic [WAYS-1:0]      plru_repl_dir_wb_o,
   output logic [WAYS-1:0]      plru_repl_dir_dirty_o,
   output logic                 plru_repl_updt_plru_o,
   input  logic [WAYS-1:0]      plru_victim_way_i
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [SETW-1:0] f_set [FIFO_DEPTH];
   logic [WAYS-1:0] f_way [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr, tptr;
   logic [CW-1:0] cnt;
   logic [RW-1:0] rr, win;
   logic [SW-1:0] scnt;
   logic rsp_valid;
   logic [WAYS-1:0] rsp_way;
   logic found, full, empty, hazard, starve, repl_gnt, pop, accept, merge, push;
   logic [SETW-1:0] win_set;
   logic [WAYS-1:0] win_way;
   int j;
   always_comb begin
      found = 1'b0;
      win = '0;
      win_set = '0;
      win_way = '0;
      j = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(rr) + i) % NREQ;
         if (!found && updt_valid_i[j]) begin
            found = 1'b1;
            win = RW'(j);
            win_set = updt_set_i[j*SETW +: SETW];
            win_way = updt_way_i[j*WAYS +: WAYS];
         end
      end
   end
   // only occupied entries count; an update arriving this cycle is ordered after the replacement
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++)
         if (CW'(k) < cnt && f_set[rptr + PW'(k)] == repl_set_i) hazard = 1'b1;
   end
   assign full     = cnt == CW'(FIFO_DEPTH);
   assign empty    = cnt == '0;
   assign starve   = scnt == SW'(STARVE_MAX);
   assign repl_gnt = ~rst_i & repl_valid_i & ~hazard & ~starve & (~rsp_valid | repl_rsp_ready_i);
   assign pop      = ~rst_i & ~empty & ~repl_gnt;
   assign accept   = ~rst_i & found & ~full;
   assign tptr     = wptr - PW'(1);
   // a repeat of the tail entry is absorbed unless that tail leaves the FIFO this cycle
   assign merge    = accept & ~empty & ~(pop & cnt == CW'(1)) & f_set[tptr] == win_set & f_way[tptr] == win_way;
   assign push     = accept & ~merge;
   assign updt_ready_o          = accept ? NREQ'(1) << win : '0;
   assign repl_ready_o          = repl_gnt;
   assign repl_rsp_valid_o      = rsp_valid & ~rst_i;
   assign repl_rsp_way_o        = rst_i ? '0 : rsp_way;
   assign plru_updt_o           = pop;
   assign plru_updt_set_o       = f_set[rptr];
   assign plru_updt_way_o       = f_way[rptr];
   assign plru_repl_o           = repl_gnt;
   assign plru_repl_set_o       = repl_set_i;
   assign plru_repl_dir_valid_o = repl_dir_valid_i;
   assign plru_repl_dir_wb_o    = repl_dir_wb_i;
   assign plru_repl_dir_dirty_o = repl_dir_dirty_i;
   assign plru_repl_updt_plru_o = repl_updt_plru_i;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
         rr        <= '0;
         scnt      <= '0;
         rsp_valid <= 1'b0;
         rsp_way   <= '0;
      end else begin
         if (push) begin
            f_set[wptr] <= win_set;
            f_way[wptr] <= win_way;
            wptr        <= wptr + PW'(1);
         end
         if (pop) rptr <= rptr + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
         if (accept) rr <= (win == RW'(NREQ - 1)) ? '0 : win + RW'(1);
         scnt <= (pop | empty) ? '0 : repl_gnt ? scnt + SW'(1) : scnt;
         if (repl_gnt) begin
            rsp_valid <= 1'b1;
            rsp_way   <= plru_victim_way_i;
         end else if (repl_rsp_ready_i) rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_hpdcache_plru_sched.sv
// tb_hpdcache_plru_sched: directed stimulus with queue scoreboard for hpdcache_plru_sched
module tb_hpdcache_plru_sched;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic [1:0] updt_valid_i, updt_ready_o;
   logic [5:0] us0, us1;
   logic [3:0] uw0, uw1;
   logic repl_valid_i, repl_ready_o, repl_updt_plru_i;
   logic [5:0] repl_set_i;
   logic [3:0] dv, dwb, ddirty;
   logic repl_rsp_valid_o, repl_rsp_ready_i;
   logic [3:0] repl_rsp_way_o;
   logic plru_updt_o, plru_repl_o, plru_repl_updt_plru_o;
   logic [5:0] plru_updt_set_o, plru_repl_set_o;
   logic [3:0] plru_updt_way_o, plru_repl_dir_valid_o, plru_repl_dir_wb_o, plru_repl_dir_dirty_o, plru_victim_way_i;
   logic [9:0] upd_q [$];
   logic [3:0] rsp_q [$];
   int n_run = 0;
   int n_fail = 0;
   always #5 clk_i = ~clk_i;
   // PLRU model: victim is the way indexed by the two low set bits
   assign plru_victim_way_i = 4'b0001 << plru_repl_set_o[1:0];
   hpdcache_plru_sched #(.SETS(64), .WAYS(4), .NREQ(2), .FIFO_DEPTH(4), .STARVE_MAX(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .updt_valid_i(updt_valid_i), .updt_ready_o(updt_ready_o),
      .updt_set_i({us1, us0}), .updt_way_i({uw1, uw0}),
      .repl_valid_i(repl_valid_i), .repl_ready_o(repl_ready_o), .repl_set_i(repl_set_i),
      .repl_dir_valid_i(dv), .repl_dir_wb_i(dwb), .repl_dir_dirty_i(ddirty),
      .repl_updt_plru_i(repl_updt_plru_i),
      .repl_rsp_valid_o(repl_rsp_valid_o), .repl_rsp_ready_i(repl_rsp_ready_i), .repl_rsp_way_o(repl_rsp_way_o),
      .plru_updt_o(plru_updt_o), .plru_updt_set_o(plru_updt_set_o), .plru_updt_way_o(plru_updt_way_o),
      .plru_repl_o(plru_repl_o), .plru_repl_set_o(plru_repl_set_o),
      .plru_repl_dir_valid_o(plru_repl_dir_valid_o), .plru_repl_dir_wb_o(plru_repl_dir_wb_o),
      .plru_repl_dir_dirty_o(plru_repl_dir_dirty_o), .plru_repl_updt_plru_o(plru_repl_updt_plru_o),
      .plru_victim_way_i(plru_victim_way_i)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [9:0] ue(input int s, input logic [3:0] w);
      return {6'(s), w};
   endfunction
   task automatic drive(input logic [1:0] uv, input int s0, input logic [3:0] w0, input int s1,
                        input logic [3:0] w1, input logic rv, input int rs);
      updt_valid_i = uv;
      us0 = 6'(s0);
      uw0 = w0;
      us1 = 6'(s1);
      uw1 = w1;
      repl_valid_i = rv;
      repl_set_i = 6'(rs);
   endtask
   task automatic smp();
      @(negedge clk_i);
   endtask
   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask
   always @(negedge clk_i) begin
      if (plru_updt_o) begin
         if (upd_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL upd_unexpected: got %0h expected none", {plru_updt_set_o, plru_updt_way_o});
         end else chk("upd_order", {22'd0, plru_updt_set_o, plru_updt_way_o}, {22'd0, upd_q.pop_front()});
      end
      if (plru_updt_o || plru_repl_o) chk("strobe_excl", {31'd0, plru_updt_o & plru_repl_o}, 0);
      if (repl_rsp_valid_o && repl_rsp_ready_i) begin
         if (rsp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL rsp_unexpected: got %0h expected none", repl_rsp_way_o);
         end else chk("rsp_way", {28'd0, repl_rsp_way_o}, {28'd0, rsp_q.pop_front()});
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: time %0t exceeds limit 100000", $time);
      $fatal(1);
   end
   initial begin
      logic [16:0] rexp4;
      logic [6:0] uexp2, rexp2;
      dv = 4'b1111;
      dwb = 4'b0101;
      ddirty = 4'b0011;
      repl_updt_plru_i = 1'b1;
      repl_rsp_ready_i = 1'b1;
      // reset with everything requesting
      drive(2'b11, 1, 4'b0001, 2, 4'b0010, 1'b1, 9);
      smp();
      chk("rst_updt_ready", {30'd0, updt_ready_o}, 0);
      chk("rst_strobes", {28'd0, repl_ready_o, plru_updt_o, plru_repl_o, repl_rsp_valid_o}, 0);
      nxt();
      rst_i = 1'b0;
      // round-robin alternation, drained one cycle later in push order
      for (int c = 0; c < 4; c++) begin
         drive(2'b11, 1, 4'b0001, 2, 4'b0010, 1'b0, 0);
         upd_q.push_back(c % 2 ? ue(2, 4'b0010) : ue(1, 4'b0001));
         smp();
         chk("t1_grant", {30'd0, updt_ready_o}, c % 2 ? 2 : 1);
         if (c == 0) chk("t1_no_bypass", {31'd0, plru_updt_o}, 0);
         nxt();
      end
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b0, 0);
      repeat (2) nxt();
      // duplicate merge while replacements block the drain
      for (int c = 0; c < 2; c++) begin
         drive(2'b01, 5, 4'b0010, 0, 4'b0, 1'b1, 20);
         if (c == 0) upd_q.push_back(ue(5, 4'b0010));
         rsp_q.push_back(4'b0001);
         smp();
         chk("t5_ready", {30'd0, updt_ready_o}, 1);
         chk("t5_repl", {31'd0, repl_ready_o}, 1);
         nxt();
      end
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b0, 0);
      nxt();
      smp();
      chk("t5_single", {31'd0, plru_updt_o}, 0);
      nxt();
      // same-set hazard
      drive(2'b01, 3, 4'b0100, 0, 4'b0, 1'b1, 9);
      upd_q.push_back(ue(3, 4'b0100));
      rsp_q.push_back(4'b0010);
      smp();
      chk("t3_grant_other", {31'd0, repl_ready_o}, 1);
      chk("t3_passthru", {13'd0, plru_repl_set_o, plru_repl_dir_valid_o, plru_repl_dir_wb_o,
          plru_repl_dir_dirty_o, plru_repl_updt_plru_o}, {13'd0, 6'd9, 4'b1111, 4'b0101, 4'b0011, 1'b1});
      nxt();
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b1, 3);
      smp();
      chk("t3_hazard", {31'd0, repl_ready_o}, 0);
      chk("t3_drain", {31'd0, plru_updt_o}, 1);
      nxt();
      drive(2'b01, 3, 4'b0001, 0, 4'b0, 1'b1, 3);
      upd_q.push_back(ue(3, 4'b0001));
      rsp_q.push_back(4'b1000);
      smp();
      chk("t3_granted", {31'd0, repl_ready_o}, 1);
      chk("t3_same_cycle_updt", {30'd0, updt_ready_o}, 1);
      nxt();
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b0, 0);
      smp();
      chk("t3_rsp_valid", {31'd0, repl_rsp_valid_o}, 1);
      nxt();
      repeat (2) nxt();
      // starvation bound: 4 grants then a forced drain
      rexp4 = 17'b1_0_1111_0_1111_0_11111;
      for (int c = 0; c < 17; c++) begin
         drive(c < 3 ? 2'b01 : 2'b00, 10 + c, 4'b0001, 0, 4'b0, 1'b1, 9);
         if (c < 3) upd_q.push_back(ue(10 + c, 4'b0001));
         if (rexp4[c]) rsp_q.push_back(4'b0010);
         smp();
         chk("t4_repl_ready", {31'd0, repl_ready_o}, {31'd0, rexp4[c]});
         chk("t4_drain", {31'd0, plru_updt_o}, {31'd0, ~rexp4[c]});
         nxt();
      end
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b0, 0);
      repeat (2) nxt();
      // full FIFO holds the fifth update, including the cycle that pops
      uexp2 = 7'b1001111;
      rexp2 = 7'b1011111;
      for (int c = 0, k = 0; c < 7; c++) begin
         drive(2'b01, 20 + k, 4'b0100, 0, 4'b0, 1'b1, 9);
         if (uexp2[c]) upd_q.push_back(ue(20 + k, 4'b0100));
         if (rexp2[c]) rsp_q.push_back(4'b0010);
         smp();
         chk("t2_updt_ready", {30'd0, updt_ready_o}, {31'd0, uexp2[c]});
         chk("t2_repl_ready", {31'd0, repl_ready_o}, {31'd0, rexp2[c]});
         if (uexp2[c]) k++;
         nxt();
      end
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b0, 0);
      repeat (6) nxt();
      // response held without consumer, then reset mid-operation
      repl_rsp_ready_i = 1'b0;
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b1, 6);
      smp();
      chk("t6_grant", {31'd0, repl_ready_o}, 1);
      nxt();
      for (int c = 0; c < 3; c++) begin
         drive(2'b01, 30 + c, 4'b1000, 0, 4'b0, 1'b1, 7);
         if (c < 2) upd_q.push_back(ue(30 + c, 4'b1000));
         smp();
         chk("t6_blocked", {31'd0, repl_ready_o}, 0);
         chk("t6_rsp_hold", {27'd0, repl_rsp_valid_o, repl_rsp_way_o}, {27'd0, 1'b1, 4'b0100});
         chk("t6_updt_ready", {30'd0, updt_ready_o}, 1);
         nxt();
      end
      rst_i = 1'b1;
      smp();
      chk("t6_rst_outputs", {23'd0, updt_ready_o, repl_ready_o, plru_updt_o, plru_repl_o, repl_rsp_valid_o,
          repl_rsp_way_o}, 0);
      nxt();
      rst_i = 1'b0;
      repl_rsp_ready_i = 1'b1;
      drive(2'b00, 0, 4'b0, 0, 4'b0, 1'b0, 0);
      for (int c = 0; c < 2; c++) begin
         smp();
         chk("t6_after_rst", {30'd0, plru_updt_o, repl_rsp_valid_o}, 0);
         nxt();
      end
      chk("upd_q_drained", upd_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
